// File: rtl/apb_rr_manager_pkg.sv
// Shared types and default widths for the
// round-robin APB manager.
package apb_rr_manager_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int APB_AW = 10;
  localparam int APB_DW = 8;

endpackage

// File: rtl/apb_rr_manager_if.sv
// APB bus bundle between the manager and
// one subordinate.
interface apb_rr_manager_if
  import apb_rr_manager_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_AW,
  parameter int DATA_WIDTH = APB_DW
);

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE,
    output PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE,
    input  PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_manager_rr_arbiter.sv
// Round-robin arbiter; owns the last-grant
// pointer, advanced on each accept strobe.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       adv,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] last;
  logic          hit;

  // Indices above the pointer first,
  // then wrap to the low end.
  always_comb begin
    gnt = '0;
    idx = last;
    hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i] && i > int'(last)) begin
        hit    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i] && i <= int'(last)) begin
        hit    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(NUM_REQ - 1);
    end else if (adv && hit) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/apb_rr_manager.sv
// APB manager sharing one subordinate among
// NUM_REQ requesters with round-robin grant.
module apb_rr_manager
  import apb_rr_manager_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = APB_AW,
  parameter int DATA_WIDTH = APB_DW,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  apb_rr_manager_if.master              apb
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  apb_state_e            state;
  logic                  go;
  logic [NUM_REQ-1:0]    cur;
  logic [CW-1:0]         wcnt;
  logic                  lwrite;
  logic [ADDR_WIDTH-1:0] laddr;
  logic [DATA_WIDTH-1:0] lwdata;

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gidx;
  logic                  any;
  logic                  adv;
  logic                  swrite;
  logic [ADDR_WIDTH-1:0] saddr;
  logic [DATA_WIDTH-1:0] swdata;

  assign any = |req_valid;
  assign adv = any &&
    ((state == IDLE && !go) ||
     (state == ACCESS && apb.PREADY));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .req   (req_valid),
    .adv   (adv),
    .gnt   (gnt),
    .idx   (gidx)
  );

  always_comb begin
    swrite = 1'b0;
    saddr  = '0;
    swdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        swrite = req_write[i];
        saddr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        swdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // `go` delays SETUP one cycle after an
  // accept from IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      go          <= 1'b0;
      cur         <= '0;
      wcnt        <= '0;
      lwrite      <= 1'b0;
      laddr       <= '0;
      lwdata      <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      apb.PSELx   <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (go) begin
            go         <= 1'b0;
            apb.PSELx  <= 1'b1;
            apb.PWRITE <= lwrite;
            apb.PADDR  <= laddr;
            apb.PWDATA <= lwdata;
            state      <= SETUP;
          end else if (any) begin
            req_ready <= gnt;
            cur       <= gnt;
            lwrite    <= swrite;
            laddr     <= saddr;
            lwdata    <= swdata;
            go        <= 1'b1;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            rsp_valid   <= cur;
            rsp_rdata   <= lwrite ? '0 : apb.PRDATA;
            rsp_err     <= apb.PSLVERR;
            wcnt        <= '0;
            apb.PENABLE <= 1'b0;
            if (any) begin
              req_ready  <= gnt;
              cur        <= gnt;
              lwrite     <= swrite;
              laddr      <= saddr;
              lwdata     <= swdata;
              apb.PWRITE <= swrite;
              apb.PADDR  <= saddr;
              apb.PWDATA <= swdata;
              state      <= SETUP;
            end else begin
              apb.PSELx <= 1'b0;
              state     <= IDLE;
            end
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            rsp_valid   <= cur;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            wcnt        <= '0;
            apb.PSELx   <= 1'b0;
            apb.PENABLE <= 1'b0;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_manager.sv
// Scoreboard bench for apb_rr_manager with a
// behavioural memory subordinate.
module tb_apb_rr_manager;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 8;

  typedef struct {
    int       idx;
    bit       err;
    bit [7:0] rdata;
  } exp_t;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  apb_rr_manager_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  apb_rr_manager #(
    .NUM_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT(16)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (bus)
  );

  always #5 PCLK = ~PCLK;

  logic [7:0] mem   [1024];
  bit   [7:0] model [1024];
  int  acnt   = 0;
  int  wait_n = 0;
  bit  hang   = 1'b0;
  bit  slverr = 1'b0;
  bit  to_flag = 1'b0;
  int  cyc    = 0;

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (bus.PSELx && bus.PENABLE && !bus.PREADY)
      acnt <= acnt + 1;
    else
      acnt <= 0;
    if (bus.PSELx && bus.PENABLE &&
        bus.PREADY && bus.PWRITE)
      mem[bus.PADDR] <= bus.PWDATA;
  end

  always_comb begin
    bus.PREADY  = !hang && (acnt >= wait_n);
    bus.PRDATA  = mem[bus.PADDR];
    bus.PSLVERR = slverr && bus.PSELx &&
                  bus.PENABLE;
  end

  exp_t sbq [$];
  int   gseq [$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cyc  = 0;
  int   rsp_cyc  = 0;
  bit   psel_at_rsp;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input int r,
                       input bit wr,
                       input logic [9:0] a,
                       input logic [7:0] d,
                       input bit keep,
                       input bit push);
    exp_t e;
    bit   seen = 1'b0;
    req_write[r] = wr;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (req_ready[r]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk($sformatf("accept_timeout_req%0d", r),
          32'd0, 32'd1);
      req_valid[r] = 1'b0;
      return;
    end
    acc_cyc = cyc;
    gseq.push_back(r);
    if (push) begin
      e.idx   = r;
      e.err   = slverr | to_flag;
      e.rdata = (wr || to_flag) ? 8'h00 : model[a];
      if (wr && !to_flag) model[a] = d;
      sbq.push_back(e);
    end
    if (!keep) req_valid[r] = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(posedge PCLK);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    @(negedge PCLK);
  endtask

  initial begin
    exp_t e;
    int   bad;
    bit   up;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 8'h00;
      model[i] = 8'h00;
    end
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    fork
      forever begin
        @(negedge PCLK);
        if (rsp_valid != '0) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp",
                32'(rsp_valid), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("rsp_valid", 32'(rsp_valid),
                32'd1 << e.idx);
            chk("rsp_err", 32'(rsp_err),
                32'(e.err));
            chk("rsp_rdata", 32'(rsp_rdata),
                32'(e.rdata));
          end
          rsp_cyc     = cyc;
          psel_at_rsp = bus.PSELx;
        end
      end
    join_none

    repeat (3) @(negedge PCLK);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_psel", 32'(bus.PSELx), 0);
    chk("rst_penable", 32'(bus.PENABLE), 0);
    chk("rst_paddr", 32'(bus.PADDR), 0);
    chk("rst_rsp", {rsp_err, rsp_rdata}, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // 1: single write, latency 3
    drive(0, 1'b1, 10'h3FF, 8'hA5, 0, 1);
    @(negedge PCLK);
    chk("t1_setup_psel", 32'(bus.PSELx), 1);
    chk("t1_setup_pen", 32'(bus.PENABLE), 0);
    chk("t1_paddr", 32'(bus.PADDR), 32'h3FF);
    chk("t1_pwrite", 32'(bus.PWRITE), 1);
    chk("t1_pwdata", 32'(bus.PWDATA), 32'hA5);
    @(negedge PCLK);
    chk("t1_access_psel", 32'(bus.PSELx), 1);
    chk("t1_access_pen", 32'(bus.PENABLE), 1);
    wait_done(20);
    chk("t1_latency", rsp_cyc - acc_cyc, 3);

    // 2: read back via requester 1
    drive(1, 1'b0, 10'h3FF, 8'h00, 0, 1);
    @(negedge PCLK);
    chk("t2_setup_paddr", 32'(bus.PADDR), 32'h3FF);
    chk("t2_setup_pwrite", 32'(bus.PWRITE), 0);
    @(negedge PCLK);
    chk("t2_acc_pen", 32'(bus.PENABLE), 1);
    chk("t2_acc_paddr", 32'(bus.PADDR), 32'h3FF);
    chk("t2_acc_pwrite", 32'(bus.PWRITE), 0);
    wait_done(20);

    // 3: both held valid, 8 transfers
    gseq.delete();
    bad = 0;
    up  = 1'b0;
    fork
      for (int n = 0; n < 4; n++)
        drive(0, 1'b1, 10'h10 + 10'(n),
              8'h30 + 8'(n), n < 3, 1);
      for (int n = 0; n < 4; n++)
        drive(1, 1'b0, 10'h3FF, 8'h00, n < 3, 1);
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge PCLK);
          if (bus.PSELx) begin
            up = 1'b1;
            break;
          end
        end
        for (int n = 0; n < 16 && up; n++) begin
          if (!bus.PSELx ||
              bus.PENABLE != n[0]) bad++;
          @(negedge PCLK);
        end
      end
    join
    chk("t3_bus_started", 32'(up), 1);
    chk("t3_psel_pen_pattern", bad, 0);
    chk("t3_grants", gseq.size(), 8);
    for (int i = 0; i < 8 && i < gseq.size(); i++)
      chk($sformatf("t3_grant%0d", i),
          gseq[i], i % 2);
    wait_done(40);

    // 4: three wait states, slave error
    wait_n = 3;
    slverr = 1'b1;
    drive(0, 1'b0, 10'h3FF, 8'h00, 0, 1);
    wait_done(30);
    chk("t4_latency", rsp_cyc - acc_cyc, 6);
    wait_n = 0;
    slverr = 1'b0;

    // 5: PREADY stuck low -> timeout
    hang    = 1'b1;
    to_flag = 1'b1;
    drive(1, 1'b0, 10'h012, 8'h00, 0, 1);
    wait_done(40);
    chk("t5_latency", rsp_cyc - acc_cyc, 18);
    chk("t5_psel_low", 32'(psel_at_rsp), 0);
    hang    = 1'b0;
    to_flag = 1'b0;

    // 6: reset mid-ACCESS, then req0 first
    hang = 1'b1;
    drive(0, 1'b1, 10'h020, 8'h11, 0, 0);
    repeat (3) @(negedge PCLK);
    chk("t6_in_access", 32'(bus.PENABLE), 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("t6_rst_bus",
        {bus.PSELx, bus.PENABLE, bus.PWRITE,
         bus.PADDR, bus.PWDATA}, 0);
    chk("t6_rst_hs",
        {req_ready, rsp_valid, rsp_err}, 0);
    hang = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    gseq.delete();
    fork
      drive(1, 1'b0, 10'h3FF, 8'h00, 0, 1);
      drive(0, 1'b0, 10'h3FF, 8'h00, 0, 1);
    join
    chk("t6_first_grant", gseq[0], 0);
    chk("t6_second_grant", gseq[1], 1);
    wait_done(30);
    chk("t6_mem_untouched", 32'(mem[10'h020]), 0);

    repeat (4) @(negedge PCLK);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
